// File: rtl/mac_accumulator.sv
// Purpose: accumulates a stream of unsigned product terms into a running sum and holds the result until it is consumed.
// Latency: acc_valid rises the cycle after the last term is accepted, and acc_out already includes that term.
// Backpressure: prod_ready drops while a result is held; acc_ready=1 releases the result, and the next term is accepted one cycle later.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   clear                 synchronous flush; discards any partial or held result
//   prod_in/_valid/_last  incoming term, its valid flag, and the end-of-sequence marker
//   prod_ready            high while collecting terms
//   acc_out/acc_valid     accumulated sum and its completed-result flag
//   acc_ready             downstream takes the held result
//   overflow              sticky wrap flag for the current sequence
//   term_count            saturating count of terms accepted in the current sequence
module mac_accumulator #(
  parameter int PROD_WIDTH = 4,
  parameter int ACC_WIDTH  = 8,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic [PROD_WIDTH-1:0] prod_in,
  input  logic                  prod_valid,
  input  logic                  prod_last,
  output logic                  prod_ready,
  output logic [ACC_WIDTH-1:0]  acc_out,
  output logic                  acc_valid,
  input  logic                  acc_ready,
  output logic                  overflow,
  output logic [CNT_WIDTH-1:0]  term_count
);

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [ACC_WIDTH-1:0]  acc_d;
  logic                  acc_valid_d;
  logic                  overflow_d;
  logic [CNT_WIDTH-1:0]  cnt_d;

  logic                  accept;
  // One spare bit on top of the sum captures the unsigned carry-out.
  logic [ACC_WIDTH:0]    sum_ext;

  assign prod_ready = (state_q == ACCUM);
  assign accept     = prod_valid && prod_ready;
  assign sum_ext    = {1'b0, acc_out}
                    + {{(ACC_WIDTH - PROD_WIDTH + 1){1'b0}}, prod_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ACCUM;
      acc_out    <= '0;
      acc_valid  <= 1'b0;
      overflow   <= 1'b0;
      term_count <= '0;
    end else begin
      state_q    <= state_d;
      acc_out    <= acc_d;
      acc_valid  <= acc_valid_d;
      overflow   <= overflow_d;
      term_count <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_out;
    acc_valid_d = acc_valid;
    overflow_d  = overflow;
    cnt_d       = term_count;

    if (clear) begin
      // Flush wins over any simultaneous accept or consume.
      state_d     = ACCUM;
      acc_d       = '0;
      acc_valid_d = 1'b0;
      overflow_d  = 1'b0;
      cnt_d       = '0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (accept) begin
            acc_d = sum_ext[ACC_WIDTH-1:0];
            if (sum_ext[ACC_WIDTH]) begin
              overflow_d = 1'b1;
            end
            if (term_count != {CNT_WIDTH{1'b1}}) begin
              cnt_d = term_count + 1'b1;
            end
            if (prod_last) begin
              state_d     = DONE;
              acc_valid_d = 1'b1;
            end
          end
        end
        DONE: begin
          // Result is frozen here; incoming terms are not accepted.
          if (acc_ready) begin
            state_d     = ACCUM;
            acc_d       = '0;
            acc_valid_d = 1'b0;
            overflow_d  = 1'b0;
            cnt_d       = '0;
          end
        end
        default: begin
          state_d = ACCUM;
        end
      endcase
    end
  end

endmodule
